// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
//   Prefetching instruction fetch unit. It issues sequential word fetches on the
//   CPU bus and buffers {pc, instruction} pairs in a DEPTH-entry queue. Decode
//   takes pairs through a valid/accept handshake, so bus latency and decode
//   stalls are decoupled from each other. A redirect (i_flush) empties the queue
//   and retargets fetching. If a bus transfer is still outstanding at that
//   point, it is allowed to complete and its word is thrown away.
//
// Parameters
//   RESET_VECTOR  first fetch address after reset
//   DEPTH         queue entries (power of two, >= 2)
//   PC_STEP       byte increment between sequential fetches
//
// Ports
//   i_clock         clock
//   i_reset         synchronous, active-high reset
//   o_request       bus request, held until i_ready is sampled high
//   i_ready         bus completion, i_data valid in the same cycle
//   o_address       fetch address, stable while o_request=1
//   i_data          instruction word from the bus
//   o_valid         head entry valid (queue not empty)
//   i_accept        decode consumes the head entry when o_valid=1
//   o_instruction   head entry instruction
//   o_pc            head entry pc
//   i_flush         redirect: discard queue and in-flight word
//   i_flush_pc      new fetch address, sampled with i_flush
//   o_stat_fetched  words pushed into the queue
//   o_stat_dropped  words discarded by flushes
//
// Build option
//   CPU_FETCH_STATS_EN  when defined, builds the two statistics counters.
//                       When it is not defined, both stat ports are tied to 0.

module cpu_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 4,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_request,
  input  logic        i_ready,
  output logic [31:0] o_address,
  input  logic [31:0] i_data,
  output logic        o_valid,
  input  logic        i_accept,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic [31:0] o_stat_fetched,
  output logic [31:0] o_stat_dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_stale_addr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];

  logic          w_push;
  logic          w_pop;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    o_request    = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_flush || (r_count < FULL_C)) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        o_request = 1'b1;
        if (i_ready) begin
          if (i_flush) begin
            // The returning word belongs to the old stream. Drop it and
            // restart immediately at the flush target.
            w_state_next = S_FETCH;
          end else begin
            w_push = 1'b1;
            // Decide on the registered count plus this push. A pop in the
            // same cycle deliberately does not buy an extra issue.
            w_state_next = (r_count < LAST_C) ? S_FETCH : S_IDLE;
          end
        end else if (i_flush) begin
          // The bus transfer cannot be aborted. Wait it out on the stale address.
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_request = 1'b1;
        if (i_ready) begin
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_valid       = (r_count != '0);
  assign w_pop         = o_valid & i_accept & ~i_flush;
  assign o_address     = (r_state == S_DRAIN) ? r_stale_addr : r_fetch_pc;
  assign o_pc          = r_mem_pc[r_rd_ptr];
  assign o_instruction = r_mem_data[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // Queue pointers, occupancy, fetch pc
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fetch_pc   <= RESET_VECTOR;
      r_stale_addr <= RESET_VECTOR;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else if (i_flush) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fetch_pc <= i_flush_pc;
      // Keep presenting the in-flight address while draining. A second flush
      // during the drain only retargets r_fetch_pc.
      if (r_state == S_FETCH) begin
        r_stale_addr <= r_fetch_pc;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Queue storage. The write address is the address currently on the bus.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      r_mem_data[r_wr_ptr] <= i_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef CPU_FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_dropped;
  logic        w_inflight_drop;
  logic [31:0] w_drop_inc;

  // A completing transfer is discarded when it returns during a drain, or
  // when it returns in the same cycle as a flush.
  assign w_inflight_drop = i_ready &
                           (((r_state == S_FETCH) & i_flush) | (r_state == S_DRAIN));
  assign w_drop_inc      = (i_flush ? 32'(r_count) : 32'd0) +
                           (w_inflight_drop ? 32'd1 : 32'd0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stat_fetched <= '0;
      r_stat_dropped <= '0;
    end else begin
      r_stat_fetched <= r_stat_fetched + {31'd0, w_push};
      r_stat_dropped <= r_stat_dropped + w_drop_inc;
    end
  end

  assign o_stat_fetched = r_stat_fetched;
  assign o_stat_dropped = r_stat_dropped;
`else
  assign o_stat_fetched = 32'd0;
  assign o_stat_dropped = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// tb_cpu_fetch_queue
//   Self-checking bench for cpu_fetch_queue. It runs directed scenarios
//   followed by a random phase. All of them are checked against a
//   transaction-level reference model: the queue is a SystemVerilog queue, and
//   the bus is modelled as one outstanding request plus a "discard" flag.
//   A second instance, with a high reset vector and DEPTH=2, covers the
//   address wrap.

module tb_cpu_fetch_queue;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 4;
  localparam logic [31:0] STEP  = 32'd4;
`ifdef CPU_FETCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        i_reset, i_ready, i_accept, i_flush;
  logic [31:0] i_data, i_flush_pc;
  logic        o_request, o_valid;
  logic [31:0] o_address, o_instruction, o_pc, o_stat_fetched, o_stat_dropped;

  // wrap instance
  logic        d2_reset, d2_ready, d2_accept, d2_flush;
  logic [31:0] d2_data, d2_flush_pc;
  logic        o2_request, o2_valid;
  logic [31:0] o2_address, o2_instruction, o2_pc, o2_stat_fetched, o2_stat_dropped;

  cpu_fetch_queue #(.RESET_VECTOR(RV), .DEPTH(DEPTH), .PC_STEP(STEP)) u_dut (
    .i_clock(clk), .i_reset(i_reset), .o_request(o_request), .i_ready(i_ready),
    .o_address(o_address), .i_data(i_data), .o_valid(o_valid), .i_accept(i_accept),
    .o_instruction(o_instruction), .o_pc(o_pc), .i_flush(i_flush),
    .i_flush_pc(i_flush_pc), .o_stat_fetched(o_stat_fetched),
    .o_stat_dropped(o_stat_dropped)
  );

  cpu_fetch_queue #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(2), .PC_STEP(32'd4)) u_dut2 (
    .i_clock(clk), .i_reset(d2_reset), .o_request(o2_request), .i_ready(d2_ready),
    .o_address(o2_address), .i_data(d2_data), .o_valid(o2_valid), .i_accept(d2_accept),
    .o_instruction(o2_instruction), .o_pc(o2_pc), .i_flush(d2_flush),
    .i_flush_pc(d2_flush_pc), .o_stat_fetched(o2_stat_fetched),
    .o_stat_dropped(o2_stat_dropped)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc;        // next sequential fetch address
  logic [31:0] m_addr;      // address of the outstanding request
  bit          m_req;       // a request is on the bus
  bit          m_discard;   // outstanding request belongs to a flushed stream
  logic [63:0] m_q[$];      // {pc, instruction}
  logic [31:0] m_fetched, m_dropped;

  task automatic model_reset();
    m_pc      = RV;
    m_addr    = RV;
    m_req     = 1'b0;
    m_discard = 1'b0;
    m_q.delete();
    m_fetched = 32'd0;
    m_dropped = 32'd0;
  endtask

  // Advance the model across one clock edge, using the inputs now driven.
  task automatic model_step();
    int n;
    bit done;
    logic [63:0] head;
    n    = m_q.size();
    done = i_ready && m_req;
    if (i_flush) begin
      m_dropped = m_dropped + 32'(n) + (done ? 32'd1 : 32'd0);
      m_q.delete();
      m_pc = i_flush_pc;
      if (m_req && !done) begin
        m_discard = 1'b1;
      end else begin
        m_req     = 1'b1;
        m_discard = 1'b0;
        m_addr    = i_flush_pc;
      end
    end else begin
      if (n != 0 && i_accept) begin
        head = m_q.pop_front();
        $display("pop pc=%h instr=%h", head[63:32], head[31:0]);
      end
      if (done) begin
        if (m_discard) begin
          m_dropped = m_dropped + 32'd1;
          m_discard = 1'b0;
          m_addr    = m_pc;
        end else begin
          m_q.push_back({m_addr, i_data});
          m_fetched = m_fetched + 32'd1;
          m_pc      = m_addr + STEP;
          m_req     = (n + 1 < DEPTH);
          m_addr    = m_pc;
        end
      end else if (!m_req && n < DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic check_outputs();
    check("req", {31'd0, o_request}, {31'd0, m_req});
    if (m_req) check("addr", o_address, m_addr);
    check("valid", {31'd0, o_valid}, {31'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      check("pc", o_pc, m_q[0][63:32]);
      check("instr", o_instruction, m_q[0][31:0]);
    end
    check("stat_fetched", o_stat_fetched, STATS_ON ? m_fetched : 32'd0);
    check("stat_dropped", o_stat_dropped, STATS_ON ? m_dropped : 32'd0);
  endtask

  // Check the current cycle, then drive this cycle's inputs.
  task automatic step(input bit rdy, input bit acc, input bit fl, input logic [31:0] fpc);
    @(negedge clk);
    check_outputs();
    i_ready    = rdy;
    i_accept   = acc;
    i_flush    = fl;
    i_flush_pc = fpc;
    i_data     = $urandom;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset  = 1'b1;
    i_ready  = 1'b0;
    i_accept = 1'b0;
    i_flush  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs();
    check("rst_addr", o_address, RV);
    i_reset = 1'b0;
    model_step();
  endtask

  initial begin
    i_reset = 1'b1; i_ready = 1'b0; i_accept = 1'b0; i_flush = 1'b0;
    i_data = 32'd0; i_flush_pc = 32'd0;
    d2_reset = 1'b1; d2_ready = 1'b0; d2_accept = 1'b0; d2_flush = 1'b0;
    d2_data = 32'd0; d2_flush_pc = 32'd0;
    model_reset();

    // 1: fill from reset with the bus always ready
    $display("scenario fill");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("t1_req", {31'd0, o_request}, 32'd1);
      check("t1_addr", o_address, 32'(4 * k));
    end
    step(1'b1, 1'b1, 1'b0, 32'd0);          // full; pulse accept
    check("t1_full_req", {31'd0, o_request}, 32'd0);
    check("t1_head_pc", o_pc, 32'h0);

    // 2: one pop re-opens exactly one fetch
    $display("scenario refill");
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("t2_head_pc", o_pc, 32'h4);
    check("t2_no_req", {31'd0, o_request}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("t2_req", {31'd0, o_request}, 32'd1);
    check("t2_addr", o_address, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("t2_stop", {31'd0, o_request}, 32'd0);

    // 3: streaming with no back-pressure
    $display("scenario stream");
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("t3_valid", {31'd0, o_valid}, 32'd1);
      check("t3_pc", o_pc, 32'(4 * k));
    end

    // 4: flush while a request is outstanding
    $display("scenario drain");
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check("t4_addr_pre", o_address, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step((k == 2), 1'b0, 1'b0, 32'd0);
      check("t4_drain_req", {31'd0, o_request}, 32'd1);
      check("t4_drain_addr", o_address, 32'h8);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("t4_new_addr", o_address, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("t4_first_pc", o_pc, 32'h100);

    // 5: flush colliding with a completion and a pop
    $display("scenario collide");
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("t5_valid", {31'd0, o_valid}, 32'd0);
    check("t5_addr", o_address, 32'h200);
    check("t5_dropped", o_stat_dropped, STATS_ON ? 32'd3 : 32'd0);

    // 6: high reset vector, DEPTH=2, address wrap
    $display("scenario wrap");
    @(negedge clk);
    check("t6_rst_addr", o2_address, 32'hFFFF_FFF8);
    check("t6_rst_req", {31'd0, o2_request}, 32'd0);
    d2_reset = 1'b0; d2_ready = 1'b1; d2_data = $urandom;
    @(negedge clk);
    check("t6_a0", o2_address, 32'hFFFF_FFF8);
    @(negedge clk);
    check("t6_a1", o2_address, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t6_stop", {31'd0, o2_request}, 32'd0);
    check("t6_head", o2_pc, 32'hFFFF_FFF8);
    d2_accept = 1'b1;
    @(negedge clk);
    d2_accept = 1'b0;
    check("t6_head2", o2_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t6_wrap_req", {31'd0, o2_request}, 32'd1);
    check("t6_wrap_addr", o2_address, 32'h0000_0000);
    d2_reset = 1'b1;

    // random phase
    $display("scenario random");
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 4, $urandom & 32'hFFFF_FFFC);
    end
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
